adder_pipe_nb: RTL

Parametrised, pipelined N-bit adder/subtractor built from SLICE-bit carry slices, one pipeline stage per slice, with valid/ready flow control on input and output. It replaces the purely combinational 4-bit ripple adder in datapaths that need wider operands, registered timing, subtraction and overflow detection. It accepts one operation per cycle and preserves ordering under back-pressure.

---
 rtl/adder_pkg.sv | 27 ++
 rtl/adder_pipe_stage.sv | 43 ++++
 rtl/adder_pipe_nb.sv | 68 ++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor: stage count helper,
// configuration check and the payload carried between carry slices.
package adder_pkg;

   // Widest operand the stage payload can carry.
   localparam int unsigned MAX_WIDTH = 64;

   function automatic int unsigned nstage(input int unsigned width, input int unsigned slice);
      return width / slice;
   endfunction

   // Legal configurations: non-zero slice, width a whole number of slices, fits the payload.
   function automatic bit cfg_ok(input int unsigned width, input int unsigned slice);
      return (slice != 0) && (width >= slice) && ((width % slice) == 0) && (width <= MAX_WIDTH);
   endfunction

   // word holds finished sum slices below the current stage and untouched A slices above it,
   // so the partial sum and the remaining A operand share one vector as the pipeline skews.
   typedef struct packed {
      logic [MAX_WIDTH-1:0] word;
      logic [MAX_WIDTH-1:0] bx;
      logic                 carry;
      logic                 cmsb;
      logic                 valid;
   } stage_t;

endpackage

// File: rtl/adder_pipe_stage.sv
// One carry slice of the pipelined adder: SLICE-bit add of slice IDX, stage register
// and valid/ready flow control.
module adder_pipe_stage
   import adder_pkg::*;
#(
   parameter int unsigned SLICE = 4,
   parameter int unsigned IDX   = 0,
   parameter bit          LAST  = 1'b0
) (
   input  logic   clk,
   input  logic   rst_n,
   input  stage_t din,
   input  logic   ready_nxt,
   output logic   ready,
   output stage_t dout
);

   logic [SLICE-1:0] a_sl;
   logic [SLICE-1:0] b_sl;
   logic [SLICE:0]   sum;
   stage_t           nxt;

   // Add this slice and splice its result into the travelling payload.
   always_comb begin
      a_sl = din.word[IDX*SLICE +: SLICE];
      b_sl = din.bx[IDX*SLICE +: SLICE];
      sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, din.carry};
      nxt  = din;
      nxt.word[IDX*SLICE +: SLICE] = sum[SLICE-1:0];
      nxt.carry = sum[SLICE];
      // Carry into the operand MSB recovered from the MSB sum bit.
      if (LAST) nxt.cmsb = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ sum[SLICE-1];
   end

   assign ready = ~dout.valid | ready_nxt;

   // Stage register: load whenever this stage is empty or its content moves on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     dout <= '0;
      else if (ready) dout <= nxt;
   end

endmodule

// File: rtl/adder_pipe_nb.sv
// Pipelined N-bit adder/subtractor with valid/ready flow control, one stage per carry slice.
module adder_pipe_nb
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cex,
   input  logic             SUB,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] S,
   output logic             CO,
   output logic             OV,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int unsigned NSTAGE = nstage(WIDTH, SLICE);

   if (!cfg_ok(WIDTH, SLICE)) begin : g_bad_cfg
      $error("adder_pipe_nb: WIDTH must be a non-zero multiple of SLICE and at most %0d", MAX_WIDTH);
   end

   stage_t cap;
   stage_t q   [NSTAGE];
   logic   rdy [NSTAGE+1];
   logic   unused_tail;

   // Operand preparation: subtraction is A + ~B + ~Cex.
   always_comb begin
      cap                  = '0;
      cap.word[WIDTH-1:0]  = A;
      cap.bx[WIDTH-1:0]    = SUB ? ~B : B;
      cap.carry            = SUB ? ~Cex : Cex;
      cap.valid            = in_valid;
   end

   assign rdy[NSTAGE] = out_ready;

   for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      if (k == 0) begin : g_first
         adder_pipe_stage #(.SLICE(SLICE), .IDX(k), .LAST(k == NSTAGE-1)) u_stage (
            .clk(clk), .rst_n(rst_n), .din(cap),
            .ready_nxt(rdy[k+1]), .ready(rdy[k]), .dout(q[k])
         );
      end else begin : g_rest
         adder_pipe_stage #(.SLICE(SLICE), .IDX(k), .LAST(k == NSTAGE-1)) u_stage (
            .clk(clk), .rst_n(rst_n), .din(q[k-1]),
            .ready_nxt(rdy[k+1]), .ready(rdy[k]), .dout(q[k])
         );
      end
   end

   assign in_ready  = rdy[0];
   assign S         = q[NSTAGE-1].word[WIDTH-1:0];
   assign CO        = q[NSTAGE-1].carry;
   assign OV        = q[NSTAGE-1].carry ^ q[NSTAGE-1].cmsb;
   assign out_valid = q[NSTAGE-1].valid;

   // Leftover B bits and payload padding of the final stage have no consumer.
   assign unused_tail = ^q[NSTAGE-1];

endmodule
